// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for the immediate generator: instruction/ImmSrc/tag in, extended immediate/tag/illegal out.
// master drives the request side and consumes the result; slave is the generator itself.
interface imm_gen_pipe_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int TAG_WIDTH   = 8
);
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [INSTR_WIDTH-1:0] instr_i;
    logic [2:0]             ImmSrc_i;
    logic [TAG_WIDTH-1:0]   tag_i;

    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [DATA_WIDTH-1:0]  immop_o;
    logic [TAG_WIDTH-1:0]   tag_o;
    logic                   illegal_o;

    modport master (
        output in_valid_i, instr_i, ImmSrc_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, immop_o, tag_o, illegal_o
    );

    modport slave (
        input  in_valid_i, instr_i, ImmSrc_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, immop_o, tag_o, illegal_o
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: 1-cycle latency, full throughput; a main+skid pair absorbs one
// item of backpressure so in_ready_o is a plain register with no path from out_ready_i.
module imm_gen_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int TAG_WIDTH   = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    imm_gen_pipe_if.slave bus
);
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
        $error("imm_gen_pipe: DATA_WIDTH must be 32 or 64");
    end
    if (INSTR_WIDTH != 32) begin : g_bad_iw
        $error("imm_gen_pipe: INSTR_WIDTH must be 32");
    end

    logic [31:0] instr;
    logic [31:0] raw32;
    logic        ill_new;
    logic        unused_opcode;

    assign instr         = bus.instr_i;
    assign unused_opcode = ^instr[6:0];

    // Every format is first formed as a 32-bit value whose bit 31 is the desired extension bit,
    // so a single signed widening covers both sign- and zero-extended modes.
    always_comb begin
        raw32   = '0;
        ill_new = 1'b0;
        case (bus.ImmSrc_i)
            3'b000:  raw32 = {{20{instr[31]}}, instr[31:20]};
            3'b001:  raw32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'b010:  raw32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            3'b011:  raw32 = {instr[31:12], 12'b0};
            3'b100:  raw32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            3'b101:  raw32 = (DATA_WIDTH == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
            3'b110:  raw32 = {27'b0, instr[19:15]};
            default: ill_new = 1'b1;
        endcase
    end

    logic [DATA_WIDTH-1:0] imm_new;
    assign imm_new = DATA_WIDTH'($signed(raw32));

    logic                  main_vld_q, main_vld_d;
    logic [DATA_WIDTH-1:0] main_imm_q, main_imm_d;
    logic [TAG_WIDTH-1:0]  main_tag_q, main_tag_d;
    logic                  main_ill_q, main_ill_d;
    logic                  skid_vld_q, skid_vld_d;
    logic [DATA_WIDTH-1:0] skid_imm_q, skid_imm_d;
    logic [TAG_WIDTH-1:0]  skid_tag_q, skid_tag_d;
    logic                  skid_ill_q, skid_ill_d;
    logic                  in_rdy_q, in_rdy_d;
    logic                  in_fire;

    assign in_fire = bus.in_valid_i && in_rdy_q;

    always_comb begin
        main_vld_d = main_vld_q;
        main_imm_d = main_imm_q;
        main_tag_d = main_tag_q;
        main_ill_d = main_ill_q;
        skid_vld_d = skid_vld_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;
        skid_ill_d = skid_ill_q;
        if (!main_vld_q || bus.out_ready_i) begin
            // in_ready is low whenever skid holds an item, so skid refill and new input never coincide.
            if (skid_vld_q) begin
                main_vld_d = 1'b1;
                main_imm_d = skid_imm_q;
                main_tag_d = skid_tag_q;
                main_ill_d = skid_ill_q;
                skid_vld_d = 1'b0;
            end else if (in_fire) begin
                main_vld_d = 1'b1;
                main_imm_d = imm_new;
                main_tag_d = bus.tag_i;
                main_ill_d = ill_new;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_vld_d = 1'b1;
            skid_imm_d = imm_new;
            skid_tag_d = bus.tag_i;
            skid_ill_d = ill_new;
        end
        in_rdy_d = !skid_vld_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_vld_q <= 1'b0;
            main_imm_q <= '0;
            main_tag_q <= '0;
            main_ill_q <= 1'b0;
            skid_vld_q <= 1'b0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_ill_q <= 1'b0;
            in_rdy_q   <= 1'b1;
        end else begin
            main_vld_q <= main_vld_d;
            main_imm_q <= main_imm_d;
            main_tag_q <= main_tag_d;
            main_ill_q <= main_ill_d;
            skid_vld_q <= skid_vld_d;
            skid_imm_q <= skid_imm_d;
            skid_tag_q <= skid_tag_d;
            skid_ill_q <= skid_ill_d;
            in_rdy_q   <= in_rdy_d;
        end
    end

    assign bus.in_ready_o  = in_rdy_q;
    assign bus.out_valid_o = main_vld_q;
    assign bus.immop_o     = main_imm_q;
    assign bus.tag_o       = main_tag_q;
    assign bus.illegal_o   = main_ill_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit and a 64-bit instance fed identical streams, checked
// against scoreboard queues filled with hand-derived expected immediates.
module tb_imm_gen_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycle = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    imm_gen_pipe_if #(.DATA_WIDTH(32)) b32 ();
    imm_gen_pipe_if #(.DATA_WIDTH(64)) b64 ();

    imm_gen_pipe #(.DATA_WIDTH(32)) dut32 (.clk_i(clk), .rst_i(rst), .bus(b32));
    imm_gen_pipe #(.DATA_WIDTH(64)) dut64 (.clk_i(clk), .rst_i(rst), .bus(b64));

    typedef struct {
        logic [63:0] imm;
        logic [7:0]  tag;
        logic        ill;
        int          cyc;
    } exp_t;

    typedef struct packed {
        logic [2:0]  src;
        logic [31:0] instr;
        logic [7:0]  tag;
        logic [63:0] e32;
        logic [63:0] e64;
        logic        ill;
    } vec_t;

    exp_t q32[$];
    exp_t q64[$];

    task automatic idle_inputs();
        b32.in_valid_i = 1'b0; b32.instr_i = '0; b32.ImmSrc_i = '0; b32.tag_i = '0;
        b64.in_valid_i = 1'b0; b64.instr_i = '0; b64.ImmSrc_i = '0; b64.tag_i = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        b32.out_ready_i = 1'b0;
        b64.out_ready_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({b32.out_valid_o, b32.in_ready_o, b32.immop_o, b32.tag_o, b32.illegal_o} !== {1'b0, 1'b1, 32'h0, 8'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset32 got v=%b r=%b imm=%h tag=%h ill=%b want v=0 r=1 imm=0 tag=0 ill=0",
                     b32.out_valid_o, b32.in_ready_o, b32.immop_o, b32.tag_o, b32.illegal_o);
        end
        n_cmp++;
        if ({b64.out_valid_o, b64.in_ready_o, b64.immop_o, b64.tag_o, b64.illegal_o} !== {1'b0, 1'b1, 64'h0, 8'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset64 got v=%b r=%b imm=%h tag=%h ill=%b want v=0 r=1 imm=0 tag=0 ill=0",
                     b64.out_valid_o, b64.in_ready_o, b64.immop_o, b64.tag_o, b64.illegal_o);
        end
    endtask

    task automatic test_formats();
        vec_t v[12];
        exp_t e;
        int   idx = 0;
        int   guard = 0;
        v[0]  = '{3'b000, 32'hFFF00093, 8'h01, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        v[1]  = '{3'b011, 32'h12345037, 8'h02, 64'h12345000, 64'h0000000012345000, 1'b0};
        v[2]  = '{3'b100, 32'hFF9FF06F, 8'h03, 64'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0};
        v[3]  = '{3'b001, 32'hFE112E23, 8'h11, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        v[4]  = '{3'b010, 32'hFE000EE3, 8'h22, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        v[5]  = '{3'b101, 32'h01F0D093, 8'h05, 64'h1F, 64'h1F, 1'b0};
        v[6]  = '{3'b101, 32'h03F0D093, 8'h06, 64'h1F, 64'h3F, 1'b0};
        v[7]  = '{3'b110, 32'h300FD073, 8'h07, 64'h1F, 64'h1F, 1'b0};
        v[8]  = '{3'b111, 32'hFFFFFFFF, 8'h08, 64'h0, 64'h0, 1'b1};
        v[9]  = '{3'b011, 32'h80000037, 8'h09, 64'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        v[10] = '{3'b000, 32'h7FF00093, 8'h0A, 64'h7FF, 64'h7FF, 1'b0};
        v[11] = '{3'b100, 32'h7FE00000, 8'h0B, 64'h000007FE, 64'h00000000000007FE, 1'b0};
        b32.out_ready_i = 1'b1;
        b64.out_ready_i = 1'b1;
        @(negedge clk);
        while (guard < 100 && (idx < 12 || q32.size() != 0 || q64.size() != 0)) begin
            if (b32.out_valid_o) begin
                n_cmp++;
                if (q32.size() == 0) begin
                    n_err++;
                    $display("FAIL fmt32_extra got tag=%h want no output", b32.tag_o);
                end else begin
                    e = q32.pop_front();
                    if (b32.immop_o !== e.imm[31:0] || b32.tag_o !== e.tag || b32.illegal_o !== e.ill || cycle - e.cyc != 1) begin
                        n_err++;
                        $display("FAIL fmt32 got imm=%h tag=%h ill=%b lat=%0d want imm=%h tag=%h ill=%b lat=1",
                                 b32.immop_o, b32.tag_o, b32.illegal_o, cycle - e.cyc, e.imm[31:0], e.tag, e.ill);
                    end
                end
            end
            if (b64.out_valid_o) begin
                n_cmp++;
                if (q64.size() == 0) begin
                    n_err++;
                    $display("FAIL fmt64_extra got tag=%h want no output", b64.tag_o);
                end else begin
                    e = q64.pop_front();
                    if (b64.immop_o !== e.imm || b64.tag_o !== e.tag || b64.illegal_o !== e.ill || cycle - e.cyc != 1) begin
                        n_err++;
                        $display("FAIL fmt64 got imm=%h tag=%h ill=%b lat=%0d want imm=%h tag=%h ill=%b lat=1",
                                 b64.immop_o, b64.tag_o, b64.illegal_o, cycle - e.cyc, e.imm, e.tag, e.ill);
                    end
                end
            end
            if (idx < 12) begin
                b32.in_valid_i = 1'b1; b32.instr_i = v[idx].instr; b32.ImmSrc_i = v[idx].src; b32.tag_i = v[idx].tag;
                b64.in_valid_i = 1'b1; b64.instr_i = v[idx].instr; b64.ImmSrc_i = v[idx].src; b64.tag_i = v[idx].tag;
                if (b32.in_ready_o === 1'b1) q32.push_back('{v[idx].e32, v[idx].tag, v[idx].ill, cycle});
                if (b64.in_ready_o === 1'b1) q64.push_back('{v[idx].e64, v[idx].tag, v[idx].ill, cycle});
                idx++;
            end else begin
                idle_inputs();
            end
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        idle_inputs();
        n_cmp++;
        if (q32.size() != 0 || q64.size() != 0 || idx != 12) begin
            n_err++;
            $display("FAIL fmt_drain got pending32=%0d pending64=%0d sent=%0d want 0 0 12", q32.size(), q64.size(), idx);
        end
        q32.delete();
        q64.delete();
    endtask

    task automatic test_backpressure();
        exp_t        e;
        logic [31:0] h_imm;
        logic [7:0]  h_tag;
        int          guard = 0;
        int          pops = 0;
        int          first_pop = 0;
        int          last_pop = 0;
        bit          pend3 = 1'b1;
        @(negedge clk);
        b32.out_ready_i = 1'b0;
        for (int t = 1; t <= 2; t++) begin
            n_cmp++;
            if (b32.in_ready_o !== 1'b1) begin
                n_err++;
                $display("FAIL bp_accept%0d got in_ready=%b want 1", t, b32.in_ready_o);
            end
            b32.in_valid_i = 1'b1; b32.ImmSrc_i = 3'b000; b32.tag_i = 8'(t);
            b32.instr_i = {12'(t * 3), 20'h00093};
            q32.push_back('{64'(t * 3), 8'(t), 1'b0, cycle});
            @(posedge clk);
            @(negedge clk);
        end
        b32.in_valid_i = 1'b1; b32.tag_i = 8'd3; b32.instr_i = {12'd9, 20'h00093};
        h_imm = b32.immop_o;
        h_tag = b32.tag_o;
        n_cmp++;
        if (b32.in_ready_o !== 1'b0 || b32.out_valid_o !== 1'b1 || h_tag !== 8'd1 || h_imm !== 32'd3) begin
            n_err++;
            $display("FAIL bp_stall got in_ready=%b v=%b tag=%h imm=%h want in_ready=0 v=1 tag=01 imm=3",
                     b32.in_ready_o, b32.out_valid_o, h_tag, h_imm);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (b32.out_valid_o !== 1'b1 || b32.immop_o !== h_imm || b32.tag_o !== h_tag || b32.in_ready_o !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d got v=%b imm=%h tag=%h r=%b want v=1 imm=%h tag=%h r=0",
                         k, b32.out_valid_o, b32.immop_o, b32.tag_o, b32.in_ready_o, h_imm, h_tag);
            end
        end
        b32.out_ready_i = 1'b1;
        while (guard < 20 && (q32.size() != 0 || pend3)) begin
            if (!pend3) b32.in_valid_i = 1'b0;
            if (b32.out_valid_o) begin
                n_cmp++;
                if (q32.size() == 0) begin
                    n_err++;
                    $display("FAIL bp_extra got tag=%h want no output", b32.tag_o);
                end else begin
                    e = q32.pop_front();
                    if (pops == 0) first_pop = cycle;
                    last_pop = cycle;
                    pops++;
                    if (b32.immop_o !== e.imm[31:0] || b32.tag_o !== e.tag || b32.illegal_o !== e.ill) begin
                        n_err++;
                        $display("FAIL bp_order got imm=%h tag=%h want imm=%h tag=%h",
                                 b32.immop_o, b32.tag_o, e.imm[31:0], e.tag);
                    end
                end
            end
            if (pend3 && b32.in_ready_o === 1'b1) begin
                q32.push_back('{64'd9, 8'd3, 1'b0, cycle});
                pend3 = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        idle_inputs();
        n_cmp++;
        if (pops != 3 || last_pop - first_pop != 2 || q32.size() != 0) begin
            n_err++;
            $display("FAIL bp_drain got pops=%0d span=%0d pending=%0d want pops=3 span=2 pending=0",
                     pops, last_pop - first_pop, q32.size());
        end
        q32.delete();
    endtask

    task automatic test_reset_full();
        @(negedge clk);
        b32.out_ready_i = 1'b0;
        for (int t = 0; t < 2; t++) begin
            b32.in_valid_i = 1'b1; b32.ImmSrc_i = 3'b000; b32.tag_i = 8'hA1 + 8'(t);
            b32.instr_i = 32'hFFF00093;
            @(posedge clk);
            @(negedge clk);
        end
        b32.in_valid_i = 1'b0;
        n_cmp++;
        if (b32.in_ready_o !== 1'b0 || b32.out_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL rst_fill got r=%b v=%b want r=0 v=1", b32.in_ready_o, b32.out_valid_o);
        end
        rst = 1'b1;
        b32.in_valid_i = 1'b1; b32.tag_i = 8'hEE;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        b32.in_valid_i = 1'b0;
        n_cmp++;
        if ({b32.out_valid_o, b32.in_ready_o, b32.immop_o, b32.tag_o, b32.illegal_o} !== {1'b0, 1'b1, 32'h0, 8'h0, 1'b0}) begin
            n_err++;
            $display("FAIL rst_mid got v=%b r=%b imm=%h tag=%h ill=%b want v=0 r=1 imm=0 tag=0 ill=0",
                     b32.out_valid_o, b32.in_ready_o, b32.immop_o, b32.tag_o, b32.illegal_o);
        end
        rst = 1'b1;
        b32.in_valid_i = 1'b1; b32.tag_i = 8'hEF;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        b32.in_valid_i = 1'b0;
        b32.out_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (b32.out_valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL rst_stale%0d got v=%b tag=%h want v=0", k, b32.out_valid_o, b32.tag_o);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_backpressure();
        test_reset_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
